// File: rtl/idma_resi_rdata_pair_if.sv
// Bundles the residual pairing block's control, read-data and sum streams.
// slave  : the pairing block (consumes start/read data, produces sums/status)
// master : the environment (issues start/read data, consumes sums/status)
//   rd_resi_mode, rd_req, rd_resi_loop_num : start controls
//   rd_rdata_vld / rd_rdata / rd_rdata_rdy : interleaved A/B read-data beats
//   resi_out_vld / resi_out_data / resi_out_last / resi_out_rdy : sum stream
//   resi_busy, resi_done                   : run status
interface idma_resi_rdata_pair_if #(
    parameter int unsigned DATA_W = 128
) ();

    logic              rd_resi_mode;
    logic              rd_req;
    logic [15:0]       rd_resi_loop_num;

    logic              rd_rdata_vld;
    logic [DATA_W-1:0] rd_rdata;
    logic              rd_rdata_rdy;

    logic              resi_out_vld;
    logic [DATA_W-1:0] resi_out_data;
    logic              resi_out_last;
    logic              resi_out_rdy;

    logic              resi_busy;
    logic              resi_done;

    modport slave (
        input  rd_resi_mode,
        input  rd_req,
        input  rd_resi_loop_num,
        input  rd_rdata_vld,
        input  rd_rdata,
        output rd_rdata_rdy,
        output resi_out_vld,
        output resi_out_data,
        output resi_out_last,
        input  resi_out_rdy,
        output resi_busy,
        output resi_done
    );

    modport master (
        output rd_resi_mode,
        output rd_req,
        output rd_resi_loop_num,
        output rd_rdata_vld,
        output rd_rdata,
        input  rd_rdata_rdy,
        input  resi_out_vld,
        input  resi_out_data,
        input  resi_out_last,
        output resi_out_rdy,
        input  resi_busy,
        input  resi_done
    );

endinterface

// File: rtl/idma_resi_rdata_pair.sv
// Residual read-path return side: pairs each fmapA read beat with the
// following fmapB beat, adds them lane-wise (signed, saturating or wrapping)
// and emits one sum beat per pair on a single-entry valid/ready output.
// Ports:
//   cclk  : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport carrying start controls, read-data stream,
//           sum stream and busy/done status
module idma_resi_rdata_pair #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LANE_W = 8,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                   cclk,
    input  logic                   rst_n,
    idma_resi_rdata_pair_if.slave  bus
);

    localparam int unsigned NUM_LANES = DATA_W / LANE_W;
    localparam int unsigned CNT_W     = 16;

    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_A,
        ST_WAIT_B,
        ST_DRAIN
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_loop_num;
    logic [CNT_W-1:0]   r_loop_cnt;
    logic [DATA_W-1:0]  r_a_beat;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_vld;
    logic               r_out_last;
    logic               r_busy;
    logic               r_done;

    logic               w_start;
    logic               w_rd_rdy;
    logic               w_rd_hs;
    logic               w_out_hs;
    logic               w_pair_last;
    logic [DATA_W-1:0]  w_sum;

    // Start is only honoured from IDLE and only in residual mode.
    assign w_start  = bus.rd_req & bus.rd_resi_mode & (r_state == ST_IDLE);
    assign w_rd_hs  = bus.rd_rdata_vld & w_rd_rdy;
    assign w_out_hs = r_out_vld & bus.resi_out_rdy;

    // Loop number is non-zero whenever WAIT_B is reachable.
    assign w_pair_last = (r_loop_cnt == CNT_W'(r_loop_num - CNT_W'(1)));

    // A beats are always takeable; B beats need room in the output register,
    // which includes the cycle it is being drained.
    always_comb begin
        w_rd_rdy = 1'b0;
        unique case (r_state)
            ST_WAIT_A: w_rd_rdy = 1'b1;
            ST_WAIT_B: w_rd_rdy = ~r_out_vld | bus.resi_out_rdy;
            default:   w_rd_rdy = 1'b0;
        endcase
    end

    // Per-lane signed add at LANE_W+1 bits; no carry crosses lanes.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [LANE_W-1:0] w_a;
        logic [LANE_W-1:0] w_b;
        logic [LANE_W:0]   w_ext;
        logic              w_ovf;

        assign w_a   = r_a_beat[g*LANE_W +: LANE_W];
        assign w_b   = bus.rd_rdata[g*LANE_W +: LANE_W];
        assign w_ext = {w_a[LANE_W-1], w_a} + {w_b[LANE_W-1], w_b};
        // Overflow when the extended sign disagrees with the lane sign bit.
        assign w_ovf = w_ext[LANE_W] ^ w_ext[LANE_W-1];

        assign w_sum[g*LANE_W +: LANE_W] =
            (SAT_EN && w_ovf) ? (w_ext[LANE_W] ? LANE_MIN : LANE_MAX)
                              : w_ext[LANE_W-1:0];
    end

    // Control FSM, A holding register and single-entry output register.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_loop_num <= '0;
            r_loop_cnt <= '0;
            r_a_beat   <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Drain first; a B-beat load below overrides this in the same cycle.
            if (w_out_hs) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_loop_num <= bus.rd_resi_loop_num;
                        r_loop_cnt <= '0;
                        if (bus.rd_resi_loop_num == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_A;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_WAIT_A: begin
                    if (w_rd_hs) begin
                        r_a_beat <= bus.rd_rdata;
                        r_state  <= ST_WAIT_B;
                    end
                end

                ST_WAIT_B: begin
                    if (w_rd_hs) begin
                        r_out_data <= w_sum;
                        r_out_vld  <= 1'b1;
                        r_out_last <= w_pair_last;
                        r_loop_cnt <= CNT_W'(r_loop_cnt + CNT_W'(1));
                        r_state    <= w_pair_last ? ST_DRAIN : ST_WAIT_A;
                    end
                end

                ST_DRAIN: begin
                    // Only the final sum can be pending here.
                    if (w_out_hs && r_out_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_rdata_rdy  = w_rd_rdy;
    assign bus.resi_out_vld  = r_out_vld;
    assign bus.resi_out_data = r_out_data;
    assign bus.resi_out_last = r_out_last;
    assign bus.resi_busy     = r_busy;
    assign bus.resi_done     = r_done;

endmodule

// File: tb/tb_idma_resi_rdata_pair.sv
// Directed bench for idma_resi_rdata_pair: one saturating and one wrapping
// instance share the same stimulus; sums and status are checked against
// hand-computed constants.
module tb_idma_resi_rdata_pair;

    logic         cclk;
    logic         rst_n;
    logic         mode;
    logic         req;
    logic [15:0]  loop_num;
    logic         vld;
    logic [127:0] data;
    logic         out_rdy;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [127:0] q_data[$];
    logic         q_last[$];

    idma_resi_rdata_pair_if #(.DATA_W(128)) bus_s ();
    idma_resi_rdata_pair_if #(.DATA_W(128)) bus_w ();

    assign bus_s.rd_resi_mode     = mode;
    assign bus_s.rd_req           = req;
    assign bus_s.rd_resi_loop_num = loop_num;
    assign bus_s.rd_rdata_vld     = vld;
    assign bus_s.rd_rdata         = data;
    assign bus_s.resi_out_rdy     = out_rdy;
    assign bus_w.rd_resi_mode     = mode;
    assign bus_w.rd_req           = req;
    assign bus_w.rd_resi_loop_num = loop_num;
    assign bus_w.rd_rdata_vld     = vld;
    assign bus_w.rd_rdata         = data;
    assign bus_w.resi_out_rdy     = out_rdy;

    idma_resi_rdata_pair #(.DATA_W(128), .LANE_W(8), .SAT_EN(1'b1)) u_sat (
        .cclk  (cclk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    idma_resi_rdata_pair #(.DATA_W(128), .LANE_W(8), .SAT_EN(1'b0)) u_wrap (
        .cclk  (cclk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Record output handshakes and done pulses, sampled mid-cycle.
    always @(negedge cclk) begin
        if (bus_s.resi_out_vld && bus_s.resi_out_rdy) begin
            q_data.push_back(bus_s.resi_out_data);
            q_last.push_back(bus_s.resi_out_last);
        end
        if (bus_s.resi_done) done_cnt++;
    end

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic start(input logic [15:0] n);
        mode = 1'b1; req = 1'b1; loop_num = n;
        tick();
        req = 1'b0;
    endtask

    // Present one beat until accepted; waited = cycles spent with rdy low.
    task automatic send_beat(input logic [127:0] d, output int waited);
        logic hs;
        hs = 1'b0; waited = 0;
        vld = 1'b1; data = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge cclk);
            if (bus_s.rd_rdata_rdy) hs = 1'b1;
            @(posedge cclk);
            #1;
            if (hs) break;
            waited++;
        end
        vld = 1'b0;
        chkb("beat_accepted", hs, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!bus_s.resi_busy) break;
            tick();
        end
        chkb("idle_timeout", bus_s.resi_busy, 1'b0);
        tick();
    endtask

    initial begin
        int w;
        int d0;
        int gap;
        rst_n = 1'b0; mode = 1'b0; req = 1'b0; loop_num = '0;
        vld = 1'b0; data = '0; out_rdy = 1'b1;

        // Reset state
        repeat (3) tick();
        chkb("rst_vld",  bus_s.resi_out_vld,  1'b0);
        chkb("rst_last", bus_s.resi_out_last, 1'b0);
        chkv("rst_data", bus_s.resi_out_data, 128'h0);
        chkb("rst_rdy",  bus_s.rd_rdata_rdy,  1'b0);
        chkb("rst_busy", bus_s.resi_busy,     1'b0);
        chkb("rst_done", bus_s.resi_done,     1'b0);
        rst_n = 1'b1;
        tick();

        // Single pair 0x05 + 0x03
        start(16'd1);
        chkb("t1_busy", bus_s.resi_busy, 1'b1);
        send_beat({16{8'h05}}, w);
        send_beat({16{8'h03}}, w);
        chkb("t1_vld",  bus_s.resi_out_vld,  1'b1);
        chkv("t1_data", bus_s.resi_out_data, {16{8'h08}});
        chkb("t1_last", bus_s.resi_out_last, 1'b1);
        tick();
        chkb("t1_done",      bus_s.resi_done,    1'b1);
        chkb("t1_busy_fall", bus_s.resi_busy,    1'b0);
        chkb("t1_vld_clr",   bus_s.resi_out_vld, 1'b0);
        tick();
        chkb("t1_done_pulse", bus_s.resi_done, 1'b0);

        // Saturation vs wrap
        start(16'd1);
        send_beat({{14{8'h10}}, 8'h80, 8'h7F}, w);
        send_beat({{14{8'h20}}, 8'hFF, 8'h01}, w);
        chkv("t2_sat",  bus_s.resi_out_data, {{14{8'h30}}, 8'h80, 8'h7F});
        chkv("t2_wrap", bus_w.resi_out_data, {{14{8'h30}}, 8'h7F, 8'h80});
        wait_idle();

        // Four pairs with a downstream stall
        q_data.delete(); q_last.delete(); d0 = done_cnt;
        start(16'd4);
        send_beat({16{8'h01}}, w);
        send_beat({16{8'h10}}, w);
        out_rdy = 1'b0;
        send_beat({16{8'h02}}, w);
        vld = 1'b1; data = {16{8'h20}};
        #1;
        chkb("t3_stall_rdy",  bus_s.rd_rdata_rdy,  1'b0);
        chkv("t3_stall_data", bus_s.resi_out_data, {16{8'h11}});
        repeat (9) tick();
        chkb("t3_stall_rdy2",  bus_s.rd_rdata_rdy,  1'b0);
        chkb("t3_stall_vld",   bus_s.resi_out_vld,  1'b1);
        chkv("t3_stall_data2", bus_s.resi_out_data, {16{8'h11}});
        chkb("t3_stall_last",  bus_s.resi_out_last, 1'b0);
        out_rdy = 1'b1;
        send_beat({16{8'h20}}, w);
        send_beat({16{8'h03}}, w);
        send_beat({16{8'h30}}, w);
        send_beat({16{8'h04}}, w);
        send_beat({16{8'h40}}, w);
        wait_idle();
        chki("t3_count", q_data.size(), 4);
        chkv("t3_beat0", q_data[0], {16{8'h11}});
        chkv("t3_beat1", q_data[1], {16{8'h22}});
        chkv("t3_beat2", q_data[2], {16{8'h33}});
        chkv("t3_beat3", q_data[3], {16{8'h44}});
        chkb("t3_last0", q_last[0], 1'b0);
        chkb("t3_last1", q_last[1], 1'b0);
        chkb("t3_last2", q_last[2], 1'b0);
        chkb("t3_last3", q_last[3], 1'b1);
        chki("t3_done_cnt", done_cnt - d0, 1);

        // Three pairs with random input gaps; first pair back-to-back
        q_data.delete(); q_last.delete();
        start(16'd3);
        send_beat(128'h01020304_05060708_090A0B0C_0D0E0F10, w);
        send_beat({16{8'h10}}, w);
        chki("t4_no_bubble", w, 0);
        gap = int'($urandom_range(5, 0)); repeat (gap) tick();
        send_beat({16{8'hF0}}, w);
        gap = int'($urandom_range(5, 0)); repeat (gap) tick();
        send_beat({16{8'h05}}, w);
        gap = int'($urandom_range(5, 0)); repeat (gap) tick();
        send_beat({8{8'hC0, 8'h40}}, w);
        gap = int'($urandom_range(5, 0)); repeat (gap) tick();
        send_beat({8{8'hC0, 8'h40}}, w);
        wait_idle();
        chki("t4_count", q_data.size(), 3);
        chkv("t4_beat0", q_data[0], 128'h11121314_15161718_191A1B1C_1D1E1F20);
        chkv("t4_beat1", q_data[1], {16{8'hF5}});
        chkv("t4_beat2", q_data[2], {8{8'h80, 8'h7F}});
        chkb("t4_last2", q_last[2], 1'b1);

        // Restart request mid-run is ignored
        q_data.delete(); q_last.delete();
        start(16'd2);
        send_beat({16{8'h01}}, w);
        send_beat({16{8'h02}}, w);
        req = 1'b1; loop_num = 16'd7;
        tick();
        req = 1'b0;
        send_beat({16{8'h01}}, w);
        send_beat({16{8'h02}}, w);
        wait_idle();
        chki("t5_count", q_data.size(), 2);
        chkb("t5_last0", q_last[0], 1'b0);
        chkb("t5_last1", q_last[1], 1'b1);

        // Zero-length start
        q_data.delete(); q_last.delete(); d0 = done_cnt;
        start(16'd0);
        chkb("t5z_done", bus_s.resi_done, 1'b1);
        chkb("t5z_busy", bus_s.resi_busy, 1'b0);
        vld = 1'b1; data = {16{8'h01}};
        tick();
        chkb("t5z_done_pulse", bus_s.resi_done,    1'b0);
        chkb("t5z_rdy",        bus_s.rd_rdata_rdy, 1'b0);
        vld = 1'b0;

        // Start without residual mode
        mode = 1'b0; req = 1'b1; loop_num = 16'd3;
        tick();
        req = 1'b0; vld = 1'b1;
        #1;
        chkb("t5m_busy", bus_s.resi_busy,    1'b0);
        chkb("t5m_rdy",  bus_s.rd_rdata_rdy, 1'b0);
        tick();
        vld = 1'b0;
        chki("t5_no_out", q_data.size(), 0);
        chki("t5_done_cnt", done_cnt - d0, 1);

        // Reset mid-run, then a clean two-pair run
        d0 = done_cnt;
        start(16'd5);
        send_beat({16{8'h01}}, w);
        send_beat({16{8'h01}}, w);
        send_beat({16{8'h01}}, w);
        send_beat({16{8'h01}}, w);
        send_beat({16{8'h55}}, w);
        rst_n = 1'b0;
        #1;
        chkv("t6_rst_data", bus_s.resi_out_data, 128'h0);
        chkb("t6_rst_vld",  bus_s.resi_out_vld,  1'b0);
        chkb("t6_rst_busy", bus_s.resi_busy,     1'b0);
        chkb("t6_rst_rdy",  bus_s.rd_rdata_rdy,  1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chki("t6_no_done", done_cnt - d0, 0);
        q_data.delete(); q_last.delete();
        start(16'd2);
        send_beat({16{8'h02}}, w);
        send_beat({16{8'h03}}, w);
        send_beat({16{8'h7E}}, w);
        send_beat({16{8'h01}}, w);
        wait_idle();
        chki("t6_count", q_data.size(), 2);
        chkv("t6_beat0", q_data[0], {16{8'h05}});
        chkv("t6_beat1", q_data[1], {16{8'h7F}});
        chkb("t6_last1", q_last[1], 1'b1);
        chki("t6_done_cnt", done_cnt - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
